// File: rtl/obstacle_one_sprite_engine_pkg.sv
// Shared types, sprite geometry and palette for the obstacle-one sprite engine.
package obstacle_pkg;

  typedef enum logic [1:0] {IDLE, RUN, WRAP} state_t;

  localparam int SPRITE_DIM = 32;

  localparam logic [11:0] COLOR1 = 12'hF00;
  localparam logic [11:0] COLOR2 = 12'h0F0;
  localparam logic [11:0] COLOR3 = 12'hFFF;

  // Code 00 is transparent and maps to black.
  function automatic logic [11:0] palette(input logic [1:0] code);
    case (code)
      2'b01:   return COLOR1;
      2'b10:   return COLOR2;
      2'b11:   return COLOR3;
      default: return 12'h000;
    endcase
  endfunction

endpackage

// File: rtl/obstacle_one_sprite_engine_if.sv
// Sprite RAM read port: engine drives the address, RAM returns data one clk later.
interface obstacle_one_sprite_engine_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport master (output addr_r, input ram_dout);
  modport slave  (input addr_r, output ram_dout);
endinterface

// File: rtl/obstacle_motion_fsm.sv
// Obstacle motion controller: owns state, x_pos and y_reg; positions change only on frame_tick.
//
// state | meaning
// IDLE  | parked at X_START, hidden, waiting for start
// RUN   | visible, moves left by speed on each frame_tick
// WRAP  | hidden for one frame after leaving the left edge
module obstacle_motion_fsm
  import obstacle_pkg::*;
#(
  parameter logic [10:0] X_START = 11'd640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        stop,
  input  logic [3:0]  speed,
  input  logic [10:0] y_pos,
  output state_t      state,
  output logic [10:0] x_pos,
  output logic [10:0] y_reg
);

  state_t      state_nxt;
  logic [10:0] x_pos_nxt;
  logic [10:0] y_reg_nxt;
  logic [10:0] speed_ext;

  assign speed_ext = {7'd0, speed};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      x_pos <= X_START;
      y_reg <= '0;
    end else begin
      state <= state_nxt;
      x_pos <= x_pos_nxt;
      y_reg <= y_reg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_pos_nxt = x_pos;
    y_reg_nxt = y_reg;
    case (state)
      IDLE: begin
        x_pos_nxt = X_START;
        if (start && !stop) state_nxt = RUN;
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
          x_pos_nxt = X_START;
        end else if (frame_tick) begin
          y_reg_nxt = y_pos;
          // speed = 0 never wraps since x_pos >= 0 always holds
          if (x_pos >= speed_ext) x_pos_nxt = x_pos - speed_ext;
          else                    state_nxt = WRAP;
        end
      end
      WRAP: begin
        if (stop) begin
          state_nxt = IDLE;
          x_pos_nxt = X_START;
        end else if (frame_tick) begin
          state_nxt = RUN;
          x_pos_nxt = X_START;
        end
      end
      default: begin
        state_nxt = IDLE;
        x_pos_nxt = X_START;
      end
    endcase
  end

endmodule

// File: rtl/obstacle_one_sprite_engine.sv
// Obstacle-one sprite render engine: RAM addressing, 2-clk pixel pipeline, palette and motion.
// Optional OBSTACLE_COLLISION_EN adds player_on input and sticky hit output.
module obstacle_one_sprite_engine
  import obstacle_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 2,
  parameter int CD         = 12,
  parameter int X_START    = 640
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          x,
  input  logic [10:0]          y,
  input  logic                 frame_tick,
  input  logic                 start,
  input  logic                 stop,
  input  logic [3:0]           speed,
  input  logic [10:0]          y_pos,
  obstacle_one_sprite_engine_if.master ram,
`ifdef OBSTACLE_COLLISION_EN
  input  logic                 player_on,
  output logic                 hit,
`endif
  output logic                 sprite_on,
  output logic [CD-1:0]        rgb,
  output logic                 active
);

  localparam int HALF = ADDR_WIDTH / 2;

  state_t      state;
  logic [10:0] x_pos;
  logic [10:0] y_reg;
  logic [10:0] x_off;
  logic [10:0] y_off;
  logic        in_region;
  logic        in_region_d1;
  logic        opaque;

  obstacle_motion_fsm #(
    .X_START (11'(X_START))
  ) u_motion (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .stop       (stop),
    .speed      (speed),
    .y_pos      (y_pos),
    .state      (state),
    .x_pos      (x_pos),
    .y_reg      (y_reg)
  );

  // Unsigned wraparound turns "left of / above the sprite" into a large offset.
  assign x_off     = x - x_pos;
  assign y_off     = y - y_reg;
  assign in_region = (x_off < 11'(SPRITE_DIM)) && (y_off < 11'(SPRITE_DIM)) && (state == RUN);
  assign ram.addr_r = {y_off[HALF-1:0], x_off[HALF-1:0]};

  assign opaque = in_region_d1 && (ram.ram_dout != '0);
  assign active = (state == RUN) || (state == WRAP);

  always_ff @(posedge clk) begin
    if (reset) begin
      in_region_d1 <= 1'b0;
      sprite_on    <= 1'b0;
      rgb          <= '0;
    end else begin
      in_region_d1 <= in_region;
      sprite_on    <= opaque;
      rgb          <= opaque ? CD'(palette(2'(ram.ram_dout))) : '0;
    end
  end

`ifdef OBSTACLE_COLLISION_EN
  logic hit_q;

  always_ff @(posedge clk) begin
    if (reset || start || stop)        hit_q <= 1'b0;
    else if (sprite_on && player_on)   hit_q <= 1'b1;
  end

  // Combinational term makes hit visible in the overlap cycle itself.
  assign hit = hit_q | (sprite_on & player_on);
`endif

endmodule

// File: tb/tb_obstacle_one_sprite_engine.sv
// Scoreboard bench for obstacle_one_sprite_engine with a 1-cycle-latency sprite RAM model.
module tb_obstacle_one_sprite_engine;

  typedef struct {
    int          due;
    logic        on;
    logic [11:0] rgb;
    int          px;
    int          py;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x, y, y_pos;
  logic        frame_tick, start, stop;
  logic [3:0]  speed;
  logic        sprite_on;
  logic [11:0] rgb;
  logic        active;
`ifdef OBSTACLE_COLLISION_EN
  logic        player_on;
  logic        hit;
`endif

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q[$];
  exp_t e;
  logic [1:0] mem [1024];

  obstacle_one_sprite_engine_if #(.ADDR_WIDTH(10), .DATA_WIDTH(2)) ram_if ();

  obstacle_one_sprite_engine dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .frame_tick (frame_tick),
    .start      (start),
    .stop       (stop),
    .speed      (speed),
    .y_pos      (y_pos),
    .ram        (ram_if),
`ifdef OBSTACLE_COLLISION_EN
    .player_on  (player_on),
    .hit        (hit),
`endif
    .sprite_on  (sprite_on),
    .rgb        (rgb),
    .active     (active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    ram_if.ram_dout <= mem[ram_if.addr_r];
  end

  // Monitor: pops every expectation whose output cycle has arrived.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      total++;
      if (sprite_on !== e.on || rgb !== e.rgb) begin
        bad++;
        $display("FAIL pix(%0d,%0d): got on=%b rgb=%h want on=%b rgb=%h",
                 e.px, e.py, sprite_on, rgb, e.on, e.rgb);
      end
    end
  end

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic drive_px(input int px, input int py, input logic on, input logic [11:0] c);
    exp_t n;
    @(negedge clk);
    x = 11'(px);
    y = 11'(py);
    n.due = cyc + 2;
    n.on  = on;
    n.rgb = c;
    n.px  = px;
    n.py  = py;
    q.push_back(n);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
      q.delete();
    end
    @(negedge clk);
    x = 11'd0;
    y = 11'd0;
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
  endtask

  // Vectors relative to the sprite origin; expectations hand-derived from the RAM image below.
  int          vdx [14] = '{0, 1, 2, 3, 1, 31, 0, -1, 0, 32, 0, 31, 5, 30};
  int          vdy [14] = '{0, 0, 0, 0, 1, 0, 31, 0, -1, 0, 32, 31, 7, 2};
  logic        von [14] = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
  logic [11:0] vrgb[14] = '{12'hFFF, 12'hF00, 12'h0F0, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF,
                            12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};

  task automatic render_set(input int bx, input int by, input logic vis);
    for (int i = 0; i < 14; i++)
      drive_px(bx + vdx[i], by + vdy[i], vis & von[i], vis ? vrgb[i] : 12'h000);
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 2'b00;
    mem[0]   = 2'b11;
    mem[1]   = 2'b01;
    mem[2]   = 2'b10;
    mem[33]  = 2'b11;
    mem[31]  = 2'b11;
    mem[992] = 2'b11;
    reset = 1'b1; x = '0; y = '0; y_pos = 11'd100;
    frame_tick = 1'b0; start = 1'b0; stop = 1'b0; speed = 4'd0;
`ifdef OBSTACLE_COLLISION_EN
    player_on = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_bit("reset_active", active, 1'b0);
    check_bit("reset_sprite_on", sprite_on, 1'b0);

    // Idle: sparse full-frame scan, nothing visible.
    for (int yy = 0; yy < 525; yy += 13)
      for (int xx = 0; xx < 800; xx += 7)
        drive_px(xx, yy, 1'b0, 12'h000);
    tick();
    render_set(640, 100, 1'b0);
    check_bit("idle_active", active, 1'b0);

    // Render alignment at the reload position, speed 0 holds.
    pulse_start();
    check_bit("run_active", active, 1'b1);
    tick();
    render_set(640, 100, 1'b1);
    tick();
    render_set(640, 100, 1'b1);

    // Motion: 10 frames at speed 4.
    pulse_stop();
    check_bit("stop_active", active, 1'b0);
    speed = 4'd4;
    pulse_start();
    repeat (10) tick();
    render_set(600, 100, 1'b1);
    y_pos = 11'd200;
    tick();
    render_set(596, 200, 1'b1);
    y_pos = 11'd100;

    // Wrap: 640 - 42*15 = 10, then 10 < 15.
    pulse_stop();
    speed = 4'd15;
    pulse_start();
    repeat (42) tick();
    render_set(10, 100, 1'b1);
    tick();
    render_set(10, 100, 1'b0);
    check_bit("wrap_active", active, 1'b1);
    tick();
    render_set(640, 100, 1'b1);

    // Control priority.
    speed = 4'd4;
    tick();
    render_set(636, 100, 1'b1);
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    check_bit("startstop_active", active, 1'b0);
    render_set(640, 100, 1'b0);
    speed = 4'd0;
    pulse_start();
    tick();
    render_set(640, 100, 1'b1);
    speed = 4'd4;
    tick();
    pulse_start();
    render_set(636, 100, 1'b1);

    // Reset while the sprite is on screen.
    @(negedge clk); x = 11'd636; y = 11'd100;
    repeat (2) @(negedge clk);
    check_bit("pre_reset_on", sprite_on, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_bit("mid_reset_on", sprite_on, 1'b0);
    check_bit("mid_reset_active", active, 1'b0);
    total++;
    if (rgb !== 12'h000) begin
      bad++;
      $display("FAIL mid_reset_rgb: got %h want 000", rgb);
    end
    reset = 1'b0;
    tick();
    render_set(640, 100, 1'b0);
    check_bit("post_reset_active", active, 1'b0);

`ifdef OBSTACLE_COLLISION_EN
    speed = 4'd0;
    pulse_start();
    tick();
    check_bit("hit_initial", hit, 1'b0);
    @(negedge clk); x = 11'd640; y = 11'd100;
    @(negedge clk); x = 11'd0; y = 11'd0;
    @(negedge clk); player_on = 1'b1;
    check_bit("hit_overlap", hit, 1'b1);
    @(negedge clk); player_on = 1'b0;
    repeat (2) @(negedge clk);
    check_bit("hit_sticky", hit, 1'b1);
    pulse_stop();
    check_bit("hit_cleared", hit, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
